dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised data memory for the single-core RISC-V datapath, replacing the fixed 64-word, word-only memory. It serves one load or store per cycle through a valid/ready request port and returns a registered response one cycle later. It supports RV32I sub-word accesses (byte/half/word, signed and unsigned loads, byte-lane stores) and flags out-of-range and illegal accesses. After reset it clears its contents with a sequenced per-word sweep.

## Interface
- ADDR_W, 32, byte-address width of req_addr
- DEPTH_WORDS, 64, number of 32-bit words; power of two, ≥ 2
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle (registered)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_funct3  in  3  RV32I funct3 of the load/store
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load result, sign/zero-extended; 0 for stores and errors
- rsp_err  out  1  access fault, valid with rsp_valid
- busy  out  1  high while reset is asserted or the clear sweep is running

## Operation
- Clock and reset are fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- FSM states:
  - CLEAR: writes 0 to word clr_idx, increments clr_idx; busy=1, req_ready=0.
  - READY: busy=0, req_ready=1.
- FSM transitions:
  - rst forces CLEAR with clr_idx=0.
  - CLEAR → READY after the word DEPTH_WORDS-1 is written.
  - READY stays READY until rst.
- Request accepted on req_valid && req_ready.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2]; lane = req_addr[1:0].
- Out of range: req_addr ≥ 4·DEPTH_WORDS → rsp_err=1, no write, rsp_rdata=0.
- Loads:
  - 000 LB: sign-extend the byte at lane.
  - 001 LH: sign-extend the half at lane[1].
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend.
- Stores: 000 SB writes req_wdata[7:0] to lane; 001 SH writes [15:0] to half lane[1]; 010 SW writes the full word. Unselected bytes are unchanged.
- Illegal funct3 (loads 011, 110, 111; stores ≥ 011) → rsp_err=1, no write, rsp_rdata=0.
- Misaligned access (half with addr[0]=1, word with addr[1:0]≠0) is handled per Configuration.
- An error response never modifies memory.

## Timing
- Reset values: req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, clr_idx=0.
- The first cycle with rst low begins the clear of word 0. req_ready rises exactly DEPTH_WORDS cycles after rst falls.
- Latency: request accepted at edge N → rsp_valid/rsp_rdata/rsp_err valid for exactly the cycle after edge N. No backpressure on responses.
- Throughput: one request per cycle, back-to-back allowed.
- Store commits at the acceptance edge. A load accepted on the next cycle to the same word returns the new data.
- req_valid while req_ready=0 is ignored; the requester must hold the request.
- rst asserted mid-sweep restarts the clear from word 0. rst asserted while a response is pending cancels the response: rsp_valid=0 on the next cycle.
- rsp_rdata and rsp_err return to 0 in cycles without rsp_valid.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined: a misaligned access gives rsp_err=1, suppresses the write, and returns rsp_rdata=0.
- `DMEM_MISALIGN_TRAP_EN` not defined: the block forces address low bits to alignment (half: addr[0]=0; word: addr[1:0]=0), performs the access, and sets rsp_err=0.

## Test plan
- Reset for 3 cycles, release → busy=1 for exactly 64 cycles, req_ready=1 on cycle 64. LW from every word returns 0.
- SW 0x8000_00F0 to addr 0x10, then LB 0x10 → 0xFFFF_FFF0; LBU 0x10 → 0x0000_00F0; LH 0x12 → 0xFFFF_8000; LW 0x10 → 0x8000_00F0.
- SW 0x1122_3344 to 0x20, SB 0xAA to 0x21, SH 0xBEEF to 0x22, LW 0x20 → 0xBEEF_AA44. The responses arrive on consecutive cycles with no gaps.
- LW 0x100 (= 4·64), then SW to 0x100, then funct3=011 load → rsp_err=1 each time, rsp_rdata=0. An LW of 0x0 afterwards still returns 0.
- LW at 0x22:
  - With the macro: rsp_err=1.
  - Without the macro: rsp_err=0 and it returns the word at 0x20.
- Assert rst at sweep cycle 30 with memory previously written → req_ready stays 0 for 64 cycles after release, and all words read 0.

Source files
------------

// File: rtl/dmem_if.sv
// Request/response bus between the datapath load/store unit and dmem_ctrl.
interface dmem_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Parametrised RV32I data memory: sub-word loads/stores, fault flagging, post-reset clear sweep.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of force-aligning them.
module dmem_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus,
  output logic   busy
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               mem_we;
  logic [IDX_W-1:0]   mem_idx;
  logic [31:0]        mem_wdata;

  logic               accept, oor, f3_ok, mis_err, req_err;
  logic [1:0]         lane;
  logic [IDX_W-1:0]   idx;
  logic [31:0]        word_rd, shifted, load_data, store_data, merged;
  logic [3:0]         bmask;

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    mem_we      = 1'b0;
    mem_idx     = clr_idx_q;
    mem_wdata   = '0;
    load_data   = '0;
    store_data  = '0;
    bmask       = '0;
    merged      = '0;
    lane        = bus.req_addr[1:0];

    accept = bus.req_valid && (state_q == ST_READY);
    oor    = bus.req_addr[ADDR_W-1:IDX_W+2] != '0;
    if (bus.req_we)
      f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    else
      f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

`ifdef DMEM_MISALIGN_TRAP_EN
    mis_err = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
              ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    // Misaligned halves/words are silently snapped down to their natural boundary.
    mis_err = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   lane = {bus.req_addr[1], 1'b0};
      2'b10:   lane = 2'b00;
      default: lane = bus.req_addr[1:0];
    endcase
`endif

    req_err = oor || !f3_ok || mis_err;
    idx     = bus.req_addr[IDX_W+1:2];
    word_rd = mem_q[idx];
    shifted = word_rd >> {lane, 3'b000};

    case (bus.req_funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = word_rd;
    endcase

    case (bus.req_funct3[1:0])
      2'b00: begin
        bmask      = 4'b0001 << lane;
        store_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        bmask      = lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        bmask      = 4'b1111;
        store_data = bus.req_wdata;
      end
    endcase

    for (int unsigned b = 0; b < 4; b++)
      merged[8*b +: 8] = bmask[b] ? store_data[8*b +: 8] : word_rd[8*b +: 8];

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_idx   = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1))
          state_d = ST_READY;
      end
      default: begin
        if (accept && bus.req_we && !req_err) begin
          mem_we    = 1'b1;
          mem_idx   = idx;
          mem_wdata = merged;
        end
      end
    endcase

    rsp_valid_d = accept;
    rsp_err_d   = accept && req_err;
    rsp_rdata_d = (accept && !req_err && !bus.req_we) ? load_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Contents are not reset directly; the sweep clears them after rst drops.
  always_ff @(posedge clk) begin
    if (mem_we && !rst)
      mem_q[mem_idx] <= mem_wdata;
  end

  assign bus.req_ready = (state_q == ST_READY);
  assign busy          = (state_q == ST_CLEAR);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: expectations queued at issue time, checked when responses appear.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  dmem_if #(.ADDR_W(32)) bus();

  dmem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(64)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
    end
  endtask

  // Drive one request for a single cycle; the DUT must be ready.
  task automatic req(input string tag, input logic we, input logic [31:0] addr,
                     input logic [2:0] f3, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee);
    exp_t e;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    bus.req_wdata  = wd;
    e.tag   = tag;
    e.rdata = er;
    e.err   = ee;
    sb.push_back(e);
    @(negedge clk);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    @(negedge clk);
  endtask

  // Called at the negedge where rst has just been released.
  task automatic sweep_check(input string tag);
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i < 64) begin
        check({tag, "_busy"},  32'(busy),          32'd1);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
      end else begin
        check({tag, "_busy_end"},  32'(busy),          32'd0);
        check({tag, "_ready_end"}, 32'(bus.req_ready), 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_rsp observed=rsp_valid expected=no_response");
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
        check({e.tag, "_err"},   32'(bus.rsp_err), 32'(e.err));
      end
    end else begin
      check("idle_rdata", bus.rsp_rdata, 32'h0);
      check("idle_err",   32'(bus.rsp_err), 32'h0);
    end
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_funct3 = '0;
    bus.req_wdata  = '0;
    rst            = 1'b1;

    @(negedge clk);
    check("rst_ready",     32'(bus.req_ready), 32'd0);
    check("rst_busy",      32'(busy),          32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata",     bus.rsp_rdata,      32'h0);
    check("rst_err",       32'(bus.rsp_err),   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sweep_check("sweep");

    for (int i = 0; i < 64; i++)
      req("lw_clear", 1'b0, 32'(i * 4), 3'b010, 32'h0, 32'h0, 1'b0);
    idle();

    req("sw_10",  1'b1, 32'h10, 3'b010, 32'h8000_00F0, 32'h0, 1'b0);
    req("lb_10",  1'b0, 32'h10, 3'b000, 32'h0, 32'hFFFF_FFF0, 1'b0);
    req("lbu_10", 1'b0, 32'h10, 3'b100, 32'h0, 32'h0000_00F0, 1'b0);
    req("lh_12",  1'b0, 32'h12, 3'b001, 32'h0, 32'hFFFF_8000, 1'b0);
    req("lw_10",  1'b0, 32'h10, 3'b010, 32'h0, 32'h8000_00F0, 1'b0);
    idle();

    req("sw_20",  1'b1, 32'h20, 3'b010, 32'h1122_3344, 32'h0, 1'b0);
    req("sb_21",  1'b1, 32'h21, 3'b000, 32'h0000_00AA, 32'h0, 1'b0);
    req("sh_22",  1'b1, 32'h22, 3'b001, 32'h0000_BEEF, 32'h0, 1'b0);
    req("lw_20",  1'b0, 32'h20, 3'b010, 32'h0, 32'hBEEF_AA44, 1'b0);
    req("lhu_22", 1'b0, 32'h22, 3'b101, 32'h0, 32'h0000_BEEF, 1'b0);
    req("lb_23",  1'b0, 32'h23, 3'b000, 32'h0, 32'hFFFF_FFBE, 1'b0);
    idle();

    req("lw_oor",   1'b0, 32'h100, 3'b010, 32'h0,         32'h0, 1'b1);
    req("sw_oor",   1'b1, 32'h100, 3'b010, 32'h1234_5678, 32'h0, 1'b1);
    req("ld_f3_3",  1'b0, 32'h0,   3'b011, 32'h0,         32'h0, 1'b1);
    req("st_f3_3",  1'b1, 32'h0,   3'b011, 32'hFFFF_FFFF, 32'h0, 1'b1);
    req("ld_f3_6",  1'b0, 32'h20,  3'b110, 32'h0,         32'h0, 1'b1);
    req("lw_0",     1'b0, 32'h0,   3'b010, 32'h0,         32'h0, 1'b0);
    idle();

`ifdef DMEM_MISALIGN_TRAP_EN
    req("lw_22_mis",  1'b0, 32'h22, 3'b010, 32'h0,         32'h0,         1'b1);
    req("lh_21_mis",  1'b0, 32'h21, 3'b001, 32'h0,         32'h0,         1'b1);
    req("sh_23_mis",  1'b1, 32'h23, 3'b001, 32'h0000_1234, 32'h0,         1'b1);
    req("lw_20_post", 1'b0, 32'h20, 3'b010, 32'h0,         32'hBEEF_AA44, 1'b0);
`else
    req("lw_22_mis",  1'b0, 32'h22, 3'b010, 32'h0,         32'hBEEF_AA44, 1'b0);
    req("lh_21_mis",  1'b0, 32'h21, 3'b001, 32'h0,         32'hFFFF_AA44, 1'b0);
    req("sh_23_mis",  1'b1, 32'h23, 3'b001, 32'h0000_1234, 32'h0,         1'b0);
    req("lw_20_post", 1'b0, 32'h20, 3'b010, 32'h0,         32'h1234_AA44, 1'b0);
`endif
    idle();

    // Interrupt a fresh sweep at cycle 30 while a store is held on the bus.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h20;
    bus.req_funct3 = 3'b010;
    bus.req_wdata  = 32'hDEAD_BEEF;
    repeat (30) @(negedge clk);
    check("mid_sweep_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    rst = 1'b0;
    sweep_check("resweep");

    for (int i = 0; i < 64; i++)
      req("lw_reclear", 1'b0, 32'(i * 4), 3'b010, 32'h0, 32'h0, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
